// File: rtl/lcd_read_ctrl_if.sv
// 8080-style LCD panel bus: strobes, bidirectional data split into drive/enable/sample.
interface lcd_read_ctrl_if #(
   parameter int unsigned DW = 16
) ();
   logic          LCD_CS;
   logic          LCD_RS;
   logic          LCD_WR;
   logic          LCD_RD;
   logic [DW-1:0] LCD_DB_O;
   logic          LCD_DB_OE;
   logic [DW-1:0] LCD_DB_I;

   modport master (
      output LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DB_O, LCD_DB_OE,
      input  LCD_DB_I
   );

   modport slave (
      input  LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DB_O, LCD_DB_OE,
      output LCD_DB_I
   );
endinterface

// File: rtl/lcd_read_ctrl.sv
// LCD read controller: one command write, bus turnaround, then DUMMY+rd_len RD strobes
// with leading dummy words dropped and each data word returned with a valid pulse.
module lcd_read_ctrl #(
   parameter int unsigned DW      = 16,
   parameter int unsigned RD_LOW  = 3,
   parameter int unsigned RD_HIGH = 2,
   parameter int unsigned DUMMY   = 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic [7:0]    cmd,
   input  logic [7:0]    rd_len,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   lcd_read_ctrl_if.master lcd
);
   localparam int unsigned CMAX = (RD_LOW > RD_HIGH) ? RD_LOW : RD_HIGH;
   localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int unsigned NW   = 9;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD_SU, S_CMD_WL, S_CMD_WH, S_TURN, S_RD_L, S_RD_H, S_FIN
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cyc_q, cyc_d;
   logic [NW-1:0]   strb_q, strb_d;
   logic [NW-1:0]   total_q, total_d;
   logic [7:0]      cmd_q, cmd_d;
   logic            cs_q, cs_d, rs_q, rs_d, wr_q, wr_d, rd_q, rd_d, oe_q, oe_d;
   logic [DW-1:0]   db_o_q, db_o_d;
   logic            busy_q, busy_d, done_q, done_d, rd_valid_q, rd_valid_d;
   logic [DW-1:0]   rd_data_q, rd_data_d;

   // Sequencing, counters and capture; outputs are then decoded from the next state.
   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      strb_d     = strb_q;
      total_d    = total_q;
      cmd_d      = cmd_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;

      unique case (state_q)
         S_IDLE: if (start) begin
            state_d = S_CMD_SU;
            cmd_d   = cmd;
            total_d = NW'(rd_len) + NW'(DUMMY);
            strb_d  = '0;
            cyc_d   = '0;
         end
         S_CMD_SU: state_d = S_CMD_WL;
         S_CMD_WL: state_d = S_CMD_WH;
         S_CMD_WH: state_d = S_TURN;
         S_TURN: begin
            cyc_d   = '0;
            state_d = (total_q == '0) ? S_FIN : S_RD_L;
         end
         S_RD_L: begin
            if (cyc_q == CW'(RD_LOW - 1)) begin
               state_d = S_RD_H;
               cyc_d   = '0;
               strb_d  = strb_q + NW'(1);
               // Sample on the RD rising edge; strobes below DUMMY are the panel's dummy reads.
               if ((10'(strb_q) + 10'd1) > 10'(DUMMY)) begin
                  rd_data_d  = lcd.LCD_DB_I;
                  rd_valid_d = 1'b1;
               end
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         S_RD_H: begin
            if (cyc_q == CW'(RD_HIGH - 1)) begin
               cyc_d   = '0;
               state_d = (strb_q == total_q) ? S_FIN : S_RD_L;
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      cs_d   = 1'b1;
      rs_d   = 1'b1;
      wr_d   = 1'b1;
      rd_d   = 1'b1;
      oe_d   = 1'b0;
      db_o_d = '0;
      busy_d = (state_d != S_IDLE);
      done_d = (state_q == S_FIN);

      unique case (state_d)
         S_CMD_SU, S_CMD_WH: begin
            cs_d = 1'b0; rs_d = 1'b0; oe_d = 1'b1; db_o_d = DW'(cmd_d);
         end
         S_CMD_WL: begin
            cs_d = 1'b0; rs_d = 1'b0; oe_d = 1'b1; db_o_d = DW'(cmd_d); wr_d = 1'b0;
         end
         S_TURN, S_RD_H: cs_d = 1'b0;
         S_RD_L: begin
            cs_d = 1'b0; rd_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         cyc_q      <= '0;
         strb_q     <= '0;
         total_q    <= '0;
         cmd_q      <= '0;
         cs_q       <= 1'b1;
         rs_q       <= 1'b1;
         wr_q       <= 1'b1;
         rd_q       <= 1'b1;
         oe_q       <= 1'b0;
         db_o_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         strb_q     <= strb_d;
         total_q    <= total_d;
         cmd_q      <= cmd_d;
         cs_q       <= cs_d;
         rs_q       <= rs_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         oe_q       <= oe_d;
         db_o_q     <= db_o_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign rd_data       = rd_data_q;
   assign rd_valid      = rd_valid_q;
   assign lcd.LCD_CS    = cs_q;
   assign lcd.LCD_RS    = rs_q;
   assign lcd.LCD_WR    = wr_q;
   assign lcd.LCD_RD    = rd_q;
   assign lcd.LCD_DB_OE = oe_q;
   assign lcd.LCD_DB_O  = db_o_q;
endmodule

// File: doc/lcd_read_ctrl.md
# lcd_read_ctrl

Read-side bus controller for the 8080-style parallel LCD interface, the counterpart of the LCD write controller. On a `start` request it owns the panel bus: it writes one command byte with RS low, turns the data bus around, and issues a configurable number of RD strobes. It discards the panel's leading dummy read(s), captures each data word, and returns it to the host side with a one-cycle valid pulse. Typical uses are reading the panel ID (0x04/0xD3), status and GRAM read-back.

## Interface
Parameters:
- `DW`, 16: data bus width.
- `RD_LOW`, 3: cycles LCD_RD is held low per read, ≥1. Sized to the panel access time.
- `RD_HIGH`, 2: cycles LCD_RD is held high between reads, ≥1.
- `DUMMY`, 1: leading reads discarded after the command, ≥0.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `start` in 1: request pulse. Honoured only when `busy`=0.
- `cmd` in 8: command byte. Latched when `start` is accepted.
- `rd_len` in 8: number of data words to return, excluding dummies. Latched when `start` is accepted.
- `busy` out 1: high from the cycle after acceptance until `done`.
- `done` out 1: one-cycle pulse at transaction end.
- `rd_data` out DW: last captured word. Held until the next capture.
- `rd_valid` out 1: one-cycle pulse when `rd_data` is updated.
- `LCD_CS` out 1: chip select, active-low.
- `LCD_RS` out 1: 0 = command, 1 = data.
- `LCD_WR` out 1: write strobe, active-low.
- `LCD_RD` out 1: read strobe, active-low.
- `LCD_DB_O` out DW: bus drive value. The command is zero-extended to DW.
- `LCD_DB_OE` out 1: 1 = controller drives the bus.
- `LCD_DB_I` in DW: bus sample.

## Operation
- All outputs are registered and decoded from the next state.
- Reset values:
  - `LCD_CS`=1, `LCD_RS`=1, `LCD_WR`=1, `LCD_RD`=1.
  - `LCD_DB_OE`=0, `LCD_DB_O`=0.
  - `busy`=0, `done`=0, `rd_valid`=0, `rd_data`=0.
  - State IDLE, all counters 0.
- States:
  - IDLE: all strobes high, CS=1, OE=0. `start` moves to CMD_SU.
  - CMD_SU, 1 cycle: CS=0, RS=0, OE=1, DB_O=cmd, WR=1.
  - CMD_WL, 1 cycle: WR=0. Bus and RS unchanged.
  - CMD_WH, 1 cycle: WR=1. Bus held.
  - TURN, 1 cycle: OE=0, RS=1, CS=0. If DUMMY+rd_len=0, go to FIN; otherwise go to RD_L.
  - RD_L, RD_LOW cycles: RD=0.
  - RD_H, RD_HIGH cycles: RD=1. Afterwards, go to RD_L if reads remain, else FIN.
  - FIN, 1 cycle: CS=1, RS=1, all strobes high, OE=0. Then IDLE.
- Capture:
  - `LCD_DB_I` is sampled on the clock edge where LCD_RD goes 0→1, i.e. leaving RD_L.
  - The first DUMMY samples are dropped.
  - Each later sample loads `rd_data`, and `rd_valid`=1 for exactly that following cycle.
- The read counter is 9 bits, counting DUMMY+rd_len total strobes. rd_len=255 with DUMMY=1 gives 256 strobes and no wrap.
- `done` and `busy`=0 are both asserted in the first IDLE cycle after FIN. `start` in that same cycle is accepted.
- `start` while `busy`=1 is ignored. `cmd` and `rd_len` changes while busy have no effect.
- Asynchronous reset mid-transaction:
  - All outputs return to their reset values immediately.
  - The bus is released (OE=0) and CS is deasserted.
  - No `done` pulse is generated.
- LCD_RD and LCD_WR are never low in the same cycle.
- OE is never 1 while RD=0.

## Timing
- Acceptance edge = cycle 0. The CMD_SU outputs are visible in cycle 1.
- WR is low in cycle 2. TURN occupies cycle 4.
- The first RD low lasts from cycle 5 for RD_LOW cycles.
- Strobe k (0-based) starts at cycle 5 + k·(RD_LOW+RD_HIGH).
- `busy` is high for 5 + (DUMMY+rd_len)·(RD_LOW+RD_HIGH) cycles. `done` follows in the next cycle.
- Defaults, rd_len=2: busy lasts 20 cycles and `done` is at cycle 21.
- Read throughput is one word per RD_LOW+RD_HIGH cycles.
- `rd_valid` comes 1 cycle after the capturing edge.

## Test plan
- **Reset:** hold rstn=0 and check every output against its reset value. Release and hold IDLE with start=0 for 10 cycles → no CS/RD/WR activity.
- **ID read:** cmd=0xD3, rd_len=3. Panel model returns 0xXXXX, 0x0000, 0x0093, 0x0041 on successive RD lows.
  - Command phase: DB_O=0x00D3 with RS=0 during the WR low.
  - Exactly 4 RD strobes.
  - `rd_valid` pulses with 0x0000, 0x0093, 0x0041. The dummy is not reported.
  - `done` at cycle 26.
- **rd_len=0 (DUMMY=0 build):** one WR strobe, zero RD strobes, `done` at cycle 6, `rd_valid` never asserts.
- **Sampling edge:** the model changes DB_I every cycle while RD=0. The captured word equals the value present at the RD rising edge. OE=0 throughout every RD low.
- **Start handling:**
  - start pulses during busy are ignored and no second command is issued.
  - A start asserted in the `done` cycle begins a new CMD_SU in the next cycle.
- **Reset mid-read:** rstn=0 during the 2nd RD low → CS=1, RD=1, OE=0 asynchronously, and no `done`. After release, a new transaction completes normally.
